// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a three-state run control FSM.
// Latency: one cycle from pc_f (imem_addr) to instr_d; imem_rdata is expected combinationally.
// Backpressure: stall_f holds PC and IF/ID; flush_d/pc_src_e bubble IF/ID; a misaligned redirect halts until rst.
//
// Ports:
//   clk, rst (async active-high)          clock and reset
//   fetch_en                              start fetching from IDLE (ignored elsewhere)
//   stall_f, flush_d                      hazard controls from the hazard unit
//   pc_src_e, pc_target_e                 redirect from Execute
//   imem_addr / imem_rdata                instruction memory request/response (combinational memory)
//   instr_d, pc_d, pc_plus4_d, valid_d    IF/ID register contents
//   misalign_err                          sticky misaligned-redirect flag
//   fetch_count                           instructions captured into IF/ID
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        stall_f,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic        target_misaligned;

  // Natural 32-bit overflow gives the required wrap from 0xFFFFFFFC to 0.
  assign pc_plus4_f        = pc_f + 32'd4;
  assign imem_addr         = pc_f;
  assign target_misaligned = (pc_target_e[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc_f         <= RESET_PC;
      instr_d      <= NOP_INSTR;
      pc_d         <= 32'd0;
      pc_plus4_d   <= 32'd0;
      valid_d      <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          // PC held; IF/ID keeps a bubble so nothing downstream sees stale data.
          instr_d <= NOP_INSTR;
          valid_d <= 1'b0;
          if (fetch_en) state <= RUN;
        end

        RUN: begin
          if (pc_src_e) begin
            // Redirect beats stall: the wrong-path instruction in IF/ID is squashed.
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
            if (target_misaligned) begin
              // Keep pc_f so the faulting context is visible, then stop for good.
              misalign_err <= 1'b1;
              state        <= HALT;
            end else begin
              pc_f <= pc_target_e;
            end
          end else begin
            if (!stall_f) pc_f <= pc_plus4_f;

            // flush_d outranks stall_f for IF/ID; pc_d/pc_plus4_d keep their old values.
            if (flush_d) begin
              instr_d <= NOP_INSTR;
              valid_d <= 1'b0;
            end else if (!stall_f) begin
              instr_d     <= imem_rdata;
              pc_d        <= pc_f;
              pc_plus4_d  <= pc_plus4_f;
              valid_d     <= 1'b1;
              fetch_count <= fetch_count + 32'd1;
            end
          end
        end

        HALT: begin
          // Only rst leaves this state; every input is ignored.
          instr_d <= NOP_INSTR;
          valid_d <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, fetch_en, stall_f, flush_d, pc_src_e;
  logic [31:0] pc_target_e, imem_rdata, imem_addr, instr_d, pc_d, pc_plus4_d, fetch_count;
  logic        valid_d, misalign_err;

  // Second instance exercising the PC wrap with a non-zero reset address.
  logic        rst2, fetch_en2;
  logic        zero2 = 1'b0;
  logic [31:0] zero32 = 32'd0;
  logic [31:0] imem_rdata2, imem_addr2, instr_d2, pc_d2, pc_plus4_d2, fetch_count2;
  logic        valid_d2, misalign_err2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instruction memory model: two fixed words, everything else tagged with its address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0062E233;
      32'h4:   return 32'h00B62423;
      default: return 32'h10000000 | a;
    endcase
  endfunction

  assign imem_rdata  = mem(imem_addr);
  assign imem_rdata2 = mem(imem_addr2);

  fetch_stage dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .stall_f(stall_f), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem_rdata(imem_rdata),
    .imem_addr(imem_addr), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  fetch_stage #(.RESET_PC(32'hFFFFFFFC)) dut2 (
    .clk(clk), .rst(rst2), .fetch_en(fetch_en2), .stall_f(zero2), .flush_d(zero2),
    .pc_src_e(zero2), .pc_target_e(zero32), .imem_rdata(imem_rdata2),
    .imem_addr(imem_addr2), .instr_d(instr_d2), .pc_d(pc_d2), .pc_plus4_d(pc_plus4_d2),
    .valid_d(valid_d2), .misalign_err(misalign_err2), .fetch_count(fetch_count2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pcd, input logic [31:0] e_p4, input logic e_v,
                           input logic e_err, input logic [31:0] e_cnt);
    check({tag, ".imem_addr"},    imem_addr,    e_pc);
    check({tag, ".instr_d"},      instr_d,      e_instr);
    check({tag, ".pc_d"},         pc_d,         e_pcd);
    check({tag, ".pc_plus4_d"},   pc_plus4_d,   e_p4);
    check({tag, ".valid_d"},      {31'd0, valid_d},      {31'd0, e_v});
    check({tag, ".misalign_err"}, {31'd0, misalign_err}, {31'd0, e_err});
    check({tag, ".fetch_count"},  fetch_count,  e_cnt);
  endtask

  typedef struct {
    logic        fe, st, fl, ps;
    logic [31:0] tgt;
    logic [31:0] e_pc, e_instr, e_pcd, e_p4;
    logic        e_v, e_err;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[15];

  task automatic drive(input logic fe, input logic st, input logic fl, input logic ps,
                       input logic [31:0] tgt);
    fetch_en = fe; stall_f = st; flush_d = fl; pc_src_e = ps; pc_target_e = tgt;
  endtask

  initial begin
    //                 fe   st   fl   ps   tgt        pc          instr          pc_d   pc+4   v    err  cnt
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,  32'h00, 32'h00000013, 32'h00, 32'h00, 1'b0,1'b0,32'd0}; // IDLE holds
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,  32'h00, 32'h00000013, 32'h00, 32'h00, 1'b0,1'b0,32'd0}; // enter RUN
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,  32'h04, 32'h0062E233, 32'h00, 32'h04, 1'b1,1'b0,32'd1}; // fetch_en drop ignored
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,  32'h08, 32'h00B62423, 32'h04, 32'h08, 1'b1,1'b0,32'd2};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,  32'h08, 32'h00B62423, 32'h04, 32'h08, 1'b1,1'b0,32'd2}; // stall
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,  32'h08, 32'h00B62423, 32'h04, 32'h08, 1'b1,1'b0,32'd2}; // stall
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0C, 32'h10000008, 32'h08, 32'h0C, 1'b1,1'b0,32'd3}; // resume at 8
    vecs[7]  = '{1'b0,1'b0,1'b1,1'b0,32'h0,  32'h10, 32'h00000013, 32'h08, 32'h0C, 1'b0,1'b0,32'd3}; // flush
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,  32'h14, 32'h10000010, 32'h10, 32'h14, 1'b1,1'b0,32'd4};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b1,32'h40, 32'h40, 32'h00000013, 32'h10, 32'h14, 1'b0,1'b0,32'd4}; // redirect+stall
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0,32'h0,  32'h44, 32'h10000040, 32'h40, 32'h44, 1'b1,1'b0,32'd5};
    vecs[11] = '{1'b1,1'b1,1'b1,1'b0,32'h0,  32'h44, 32'h00000013, 32'h40, 32'h44, 1'b0,1'b0,32'd5}; // flush over stall
    vecs[12] = '{1'b0,1'b0,1'b0,1'b1,32'h42, 32'h44, 32'h00000013, 32'h40, 32'h44, 1'b0,1'b1,32'd5}; // misaligned
    vecs[13] = '{1'b1,1'b0,1'b0,1'b1,32'h80, 32'h44, 32'h00000013, 32'h40, 32'h44, 1'b0,1'b1,32'd5}; // HALT ignores
    vecs[14] = '{1'b0,1'b0,1'b0,1'b0,32'h0,  32'h44, 32'h00000013, 32'h40, 32'h44, 1'b0,1'b1,32'd5};

    rst = 1'b1; rst2 = 1'b1; fetch_en2 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    check_all("reset", 32'h0, 32'h00000013, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    check("reset2.imem_addr", imem_addr2, 32'hFFFFFFFC);

    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].fe, vecs[i].st, vecs[i].fl, vecs[i].ps, vecs[i].tgt);
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pcd,
                vecs[i].e_p4, vecs[i].e_v, vecs[i].e_err, vecs[i].e_cnt);
    end

    // Asynchronous reset out of HALT, between clock edges.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2 rst = 1'b1;
    #1 check_all("halt_rst", 32'h0, 32'h00000013, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    @(negedge clk); rst = 1'b0; fetch_en = 1'b1;
    @(posedge clk); #1;
    check("restart.imem_addr", imem_addr, 32'h0);
    @(negedge clk); fetch_en = 1'b0;
    @(posedge clk); #1;
    check_all("restart_fetch", 32'h4, 32'h0062E233, 32'h0, 32'h4, 1'b1, 1'b0, 32'd1);
    @(posedge clk); #1;
    check("run2.imem_addr", imem_addr, 32'h8);

    // Asynchronous reset mid-RUN: outputs must clear before the next edge.
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_all("run_rst", 32'h0, 32'h00000013, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    #1 rst = 1'b0;

    // Wrap-around from RESET_PC = 0xFFFFFFFC.
    @(negedge clk); rst2 = 1'b0; fetch_en2 = 1'b1;
    @(posedge clk); #1;
    check("wrap.first_addr", imem_addr2, 32'hFFFFFFFC);
    @(negedge clk); fetch_en2 = 1'b0;
    @(posedge clk); #1;
    check("wrap.second_addr", imem_addr2, 32'h00000000);
    check("wrap.pc_d", pc_d2, 32'hFFFFFFFC);
    check("wrap.pc_plus4_d", pc_plus4_d2, 32'h00000000);
    check("wrap.instr_d", instr_d2, 32'hFFFFFFFC);
    check("wrap.err", {31'd0, misalign_err2}, 32'd0);
    check("wrap.count", fetch_count2, 32'd1);
    check("wrap.valid", {31'd0, valid_d2}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h00000000, giving the first fetch address after reset.
REQ-002 The module SHALL have parameter NOP_INSTR, default 32'h00000013, giving the bubble instruction loaded into instr_d.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port fetch_en, input, 1 bit: starts fetching from IDLE.
REQ-006 Port stall_f, input, 1 bit: hold the PC and the IF/ID register (load-use hazard).
REQ-007 Port flush_d, input, 1 bit: turn the IF/ID content into a bubble.
REQ-008 Port pc_src_e, input, 1 bit: taken branch or jump redirect from Execute.
REQ-009 Port pc_target_e, input, 32 bits: redirect target address.
REQ-010 Port imem_rdata, input, 32 bits: instruction word returned combinationally for imem_addr.
REQ-011 Port imem_addr, output, 32 bits: current fetch PC (pc_f) driven to the instruction memory.
REQ-012 Port instr_d, output, 32 bits: IF/ID instruction.
REQ-013 Port pc_d, output, 32 bits: IF/ID PC.
REQ-014 Port pc_plus4_d, output, 32 bits: IF/ID PC+4.
REQ-015 Port valid_d, output, 1 bit: IF/ID holds a real instruction.
REQ-016 Port misalign_err, output, 1 bit: sticky flag for a misaligned redirect target.
REQ-017 Port fetch_count, output, 32 bits: count of instructions accepted into IF/ID.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN and HALT.
REQ-019 In IDLE, the block SHALL hold pc_f and load a bubble into IF/ID at every edge; it SHALL move to RUN at the edge where fetch_en=1.
REQ-020 In RUN, next-PC priority SHALL be: pc_src_e first (pc_f <= pc_target_e), then stall_f (pc_f held), otherwise pc_f <= pc_f+4.
REQ-021 PC+4 SHALL be computed modulo 2^32; 32'hFFFFFFFC SHALL wrap to 32'h00000000 with no error.
REQ-022 imem_addr SHALL equal pc_f combinationally, so instruction-fetch latency is one cycle from PC to instr_d.
REQ-023 In RUN, IF/ID update priority SHALL be:
  - flush_d or pc_src_e: instr_d=NOP_INSTR, valid_d=0, pc_d and pc_plus4_d unchanged.
  - else stall_f: IF/ID held.
  - else capture imem_rdata, pc_f, pc_f+4 and set valid_d=1.
REQ-024 fetch_count SHALL increment by 1 (wrapping) only on an edge where the capture case of REQ-023 occurs.
REQ-025 A pc_src_e=1 with pc_target_e[1:0]!=0 SHALL:
  - leave pc_f unchanged;
  - set misalign_err=1;
  - bubble IF/ID;
  - move the FSM to HALT.
REQ-026 In HALT:
  - pc_f and fetch_count SHALL be frozen;
  - IF/ID SHALL be loaded with a bubble every edge;
  - all inputs SHALL be ignored;
  - the FSM SHALL leave HALT only on rst.
REQ-027 fetch_en SHALL be ignored outside IDLE; deasserting it in RUN SHALL have no effect.
REQ-028 Simultaneous stall_f=1 and pc_src_e=1 SHALL redirect and bubble; the redirect wins.

Reset
REQ-029 While rst=1, regardless of clk, the block SHALL force:
  - state=IDLE;
  - pc_f=RESET_PC;
  - instr_d=NOP_INSTR;
  - pc_d=0 and pc_plus4_d=0;
  - valid_d=0;
  - misalign_err=0;
  - fetch_count=0.
REQ-030 Reset asserted mid-operation, including in HALT, SHALL abandon all state immediately; the first fetch after release SHALL be from RESET_PC once fetch_en=1.

Verification
REQ-031 Sequential fetch: reset, fetch_en=1, memory word at address 0 = 0x0062E233, at address 4 = 0x00B62423 -> one edge after entering RUN, instr_d=0x0062E233, pc_d=0, pc_plus4_d=4, valid_d=1; next edge instr_d=0x00B62423, pc_d=4; fetch_count=2.
REQ-032 Stall: stall_f=1 for 2 cycles at pc_f=8 -> pc_f stays 8; instr_d, pc_d and fetch_count are unchanged; fetching resumes at 8 when stall_f falls.
REQ-033 Redirect with simultaneous stall: pc_src_e=1, pc_target_e=0x40, stall_f=1 -> next cycle pc_f=0x40, valid_d=0, instr_d=0x00000013; following edge pc_d=0x40.
REQ-034 Misaligned target: pc_src_e=1, pc_target_e=0x42 -> misalign_err=1, FSM in HALT, pc_f unchanged, valid_d=0 thereafter; fetch_en and pc_src_e pulses have no effect; rst clears all.
REQ-035 Wrap-around and async reset:
  - RESET_PC=0xFFFFFFFC -> the second fetch address is 0x00000000.
  - rst pulsed between clock edges mid-RUN -> outputs reach reset values before the next edge.
